pwm_sequencer: RTL and testbench

PWM_SEQUENCER -- requirements
Module: pwm_sequencer

---
 rtl/pwm_sequencer_pkg.sv | 20 ++
 rtl/pwm_sequencer_pwm.sv | 31 +++
 rtl/pwm_sequencer.sv | 129 ++++++++++++
 tb/tb_pwm_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sequencer_pkg
// Brief    : Shared types and default sizes for the PWM sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_sequencer_pkg;

    localparam int c_WIDTH   = 16;
    localparam int c_CNT_W   = 4;
    localparam int c_NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage : pwm_sequencer_pkg
`default_nettype wire

// File: rtl/pwm_sequencer_pwm.sv
`default_nettype none
// ============================================================================
// Module   : pwm
// Brief    : Parallel-load rotating shift register, MSB presented first.
// Revision : 1.0 - initial release
// ============================================================================
module pwm #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    input  logic             load,
    output logic             out
);

    logic [WIDTH-1:0] r_shreg;

    // No reset: contents are only meaningful after a load, and the
    // sequencer gates the output outside of RUN.
    always_ff @(posedge clk) begin
        if (load) begin
            r_shreg <= in;
        end else begin
            r_shreg <= {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
        end
    end

    assign out = r_shreg[WIDTH-1];

endmodule : pwm
`default_nettype wire

// File: rtl/pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sequencer
// Brief    : Two-requester round-robin arbiter that plays a latched pattern
//            a programmable number of periods through the pwm shifter.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sequencer
    import pwm_sequencer_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CNT_W = c_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [c_NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]     pat0,
    input  logic [WIDTH-1:0]     pat1,
    input  logic [CNT_W-1:0]     periods0,
    input  logic [CNT_W-1:0]     periods1,
    output logic [c_NUM_REQ-1:0] gnt,
    output logic                 busy,
    output logic                 done,
    output logic                 pwm_out
);

    localparam int                 c_BIT_W   = $clog2(WIDTH);
    localparam logic [c_BIT_W-1:0] c_BIT_MAX = c_BIT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_NUM_REQ-1:0] r_gnt;
    logic                 r_prio;
    logic [WIDTH-1:0]     r_pat;
    logic [CNT_W-1:0]     r_per_lat;
    logic [CNT_W-1:0]     r_percnt;
    logic [c_BIT_W-1:0]   r_bitcnt;

    logic                 w_winner;
    logic                 w_grant;
    logic                 w_load;
    logic                 w_done;
    logic                 w_held;
    logic                 w_last;
    logic                 w_pwm;
    logic [CNT_W-1:0]     w_per_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        // r_prio names the favoured requester when both are asking.
        w_winner    = (req == 2'b11) ? r_prio : req[1];
        w_per_sel   = w_winner ? periods1 : periods0;
        w_held      = |(req & r_gnt);
        w_last      = (r_bitcnt == c_BIT_MAX) && (r_percnt == CNT_W'(1));
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = w_held ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!w_held) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_prio    <= 1'b0;
            r_pat     <= '0;
            r_per_lat <= '0;
            r_percnt  <= '0;
            r_bitcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_gnt     <= w_winner ? 2'b10 : 2'b01;
                r_prio    <= ~w_winner;
                r_pat     <= w_winner ? pat1 : pat0;
                r_per_lat <= (w_per_sel == '0) ? CNT_W'(1) : w_per_sel;
            end else if (w_state_nxt == ST_IDLE) begin
                r_gnt <= '0;
            end
            if (r_state == ST_LOAD) begin
                r_bitcnt <= '0;
                r_percnt <= r_per_lat;
            end else if (r_state == ST_RUN) begin
                if (r_bitcnt == c_BIT_MAX) begin
                    r_bitcnt <= '0;
                    r_percnt <= r_percnt - 1'b1;
                end else begin
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
            end
        end
    end

    pwm #(
        .WIDTH (WIDTH)
    ) u_pwm (
        .in   (r_pat),
        .clk  (clk),
        .load (w_load),
        .out  (w_pwm)
    );

    assign gnt     = r_gnt;
    assign busy    = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign done    = w_done;
    assign pwm_out = (r_state == ST_RUN) && w_pwm;

endmodule : pwm_sequencer
`default_nettype wire

// File: tb/tb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_sequencer
// Brief    : Directed self-checking bench for pwm_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [15:0] pat0, pat1;
    logic [3:0]  periods0, periods1;
    logic [1:0]  gnt;
    logic        busy, done, pwm_out;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pwm_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .pat0     (pat0),
        .pat1     (pat1),
        .periods0 (periods0),
        .periods1 (periods1),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .pwm_out  (pwm_out)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", gnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_total++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm: got %b expected 0", pwm_out); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        logic [15:0] p;
        p = 16'hAAAA;
        pat0 = p; periods0 = 4'd1; req = 2'b01;
        tick;
        n_total++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b expected 01", gnt); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_load_busy: got %b expected 1", busy); else n_pass++;
        n_total++; if (pwm_out !== 1'b0) $display("FAIL single_load_pwm: got %b expected 0", pwm_out); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            tick;
            n_total++;
            if (pwm_out !== p[15-i]) $display("FAIL single_bit%0d: got %b expected %b", i, pwm_out, p[15-i]);
            else n_pass++;
            n_total++;
            if (done !== (i == 15)) $display("FAIL single_done%0d: got %b expected %b", i, done, (i == 15));
            else n_pass++;
        end
        tick;
        n_total++; if (gnt !== 2'b00) $display("FAIL single_end_gnt: got %b expected 00", gnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL single_end_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL single_end_done: got %b expected 0", done); else n_pass++;
        req = 2'b00;
        tick;
    endtask

    task automatic test_multi;
        int  busy_cnt, done_cnt, errs;
        logic exp_bit;
        busy_cnt = 0; done_cnt = 0; errs = 0;
        pat1 = 16'hF0F0; periods1 = 4'd3; req = 2'b10;
        tick;
        n_total++; if (gnt !== 2'b10) $display("FAIL multi_gnt: got %b expected 10", gnt); else n_pass++;
        // Inputs changed mid-grant must not disturb the latched request.
        pat1 = 16'h0000; periods1 = 4'd0;
        for (int j = 0; j < 49; j++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            exp_bit = (j == 0) ? 1'b0 : ((((j - 1) / 4) % 2) == 0);
            if (pwm_out !== exp_bit) errs++;
            tick;
        end
        n_total++; if (errs != 0) $display("FAIL multi_pattern: got %0d bad bits expected 0", errs); else n_pass++;
        n_total++; if (busy_cnt != 49) $display("FAIL multi_busy_cycles: got %0d expected 49", busy_cnt); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL multi_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL multi_end_busy: got %b expected 0", busy); else n_pass++;
        req = 2'b00;
        tick;
    endtask

    task automatic test_contention;
        logic [1:0] grants [4];
        logic [1:0] prev;
        int ng, bad;
        ng = 0; bad = 0; prev = 2'b00;
        for (int k = 0; k < 4; k++) grants[k] = 2'b00;
        pat0 = 16'hFFFF; pat1 = 16'h0001; periods0 = 4'd1; periods1 = 4'd1;
        req = 2'b11;
        for (int cyc = 0; cyc < 200 && ng < 4; cyc++) begin
            tick;
            if (gnt === 2'b11) bad++;
            if (prev != 2'b00 && gnt != 2'b00 && gnt != prev) bad++;
            if (prev == 2'b00 && gnt != 2'b00) begin
                grants[ng] = gnt;
                ng++;
            end
            prev = gnt;
        end
        req = 2'b00;
        tick;
        tick;
        n_total++; if (ng != 4) $display("FAIL cont_grant_count: got %0d expected 4", ng); else n_pass++;
        n_total++; if (bad != 0) $display("FAIL cont_overlap: got %0d bad cycles expected 0", bad); else n_pass++;
        n_total++; if (grants[0] !== 2'b01) $display("FAIL cont_g0: got %b expected 01", grants[0]); else n_pass++;
        n_total++; if (grants[1] !== 2'b10) $display("FAIL cont_g1: got %b expected 10", grants[1]); else n_pass++;
        n_total++; if (grants[2] !== 2'b01) $display("FAIL cont_g2: got %b expected 01", grants[2]); else n_pass++;
        n_total++; if (grants[3] !== 2'b10) $display("FAIL cont_g3: got %b expected 10", grants[3]); else n_pass++;
        n_total++; if (gnt !== 2'b00) $display("FAIL cont_end_gnt: got %b expected 00", gnt); else n_pass++;
    endtask

    task automatic test_zero_periods;
        int bc, dc;
        logic [15:0] obs;
        bc = 0; dc = 0; obs = 16'h0000;
        pat0 = 16'h8001; periods0 = 4'd0; req = 2'b01;
        tick;
        for (int k = 0; k < 40; k++) begin
            if (busy) bc++;
            if (k >= 1 && k <= 16) obs[16-k] = pwm_out;
            if (done) begin
                dc++;
                tick;
                break;
            end
            tick;
        end
        req = 2'b00;
        n_total++; if (bc != 17) $display("FAIL zero_busy_cycles: got %0d expected 17", bc); else n_pass++;
        n_total++; if (dc != 1) $display("FAIL zero_done_count: got %0d expected 1", dc); else n_pass++;
        n_total++; if (obs !== 16'h8001) $display("FAIL zero_pattern: got %h expected 8001", obs); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL zero_end_busy: got %b expected 0", busy); else n_pass++;
        tick;
    endtask

    task automatic test_abort;
        pat0 = 16'hFFFF; periods0 = 4'd2; req = 2'b01;
        tick;
        for (int k = 0; k < 5; k++) tick;
        n_total++; if (pwm_out !== 1'b1) $display("FAIL abort_run_pwm: got %b expected 1", pwm_out); else n_pass++;
        req = 2'b00;
        #1;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done_pre: got %b expected 0", done); else n_pass++;
        tick;
        n_total++; if (gnt !== 2'b00) $display("FAIL abort_gnt: got %b expected 00", gnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (pwm_out !== 1'b0) $display("FAIL abort_pwm: got %b expected 0", pwm_out); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else n_pass++;
        tick;
    endtask

    task automatic test_async_reset;
        pat0 = 16'hFFFF; periods0 = 4'd1; req = 2'b01;
        tick;
        tick;
        tick;
        n_total++; if (pwm_out !== 1'b1) $display("FAIL areset_run_pwm: got %b expected 1", pwm_out); else n_pass++;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (gnt !== 2'b00) $display("FAIL areset_gnt: got %b expected 00", gnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (pwm_out !== 1'b0) $display("FAIL areset_pwm: got %b expected 0", pwm_out); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL areset_done: got %b expected 0", done); else n_pass++;
        @(negedge clk);
        req = 2'b11;
        tick;
        reset_n = 1'b1;
        tick;
        n_total++; if (gnt !== 2'b01) $display("FAIL areset_first_gnt: got %b expected 01", gnt); else n_pass++;
        req = 2'b00;
        tick;
        tick;
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 2'b00;
        pat0     = 16'h0000;
        pat1     = 16'h0000;
        periods0 = 4'd0;
        periods1 = 4'd0;
        test_reset;
        test_single;
        test_multi;
        test_contention;
        test_zero_periods;
        test_abort;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pwm_sequencer
`default_nettype wire
